// File: rtl/vga_pkg.sv
// Shared timing defaults, capture FSM state type and FIFO entry layout for the VGA capture path.
package vga_pkg;

  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_H_ACTIVE  = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_V_ACTIVE  = 480;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;

  localparam int unsigned WORDS_PER_LINE = DEF_H_ACTIVE / 32;
  localparam int unsigned CNT_W          = 10;
  localparam int unsigned WORD_W         = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_VSYNC = 2'd1,
    CAPTURE    = 2'd2,
    DRAIN      = 2'd3
  } cap_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/vga_capture_fifo.sv
// Two-entry register FIFO of {addr,data}; head is always held in e0 so outputs come straight from flops.
module vga_capture_fifo
  import vga_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  fifo_entry_t push_entry_i,
  input  logic        pop_i,
  output fifo_entry_t head_o,
  output logic        empty_o,
  output logic        full_o
);

  fifo_entry_t e0_q;
  fifo_entry_t e1_q;
  logic [1:0]  cnt_q;
  logic        do_pop;
  logic        do_push;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted alongside a pop.
  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_q <= push_entry_i;
          else               e1_q <= push_entry_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          e0_q  <= e1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_q <= push_entry_i;
          end else begin
            e0_q <= e1_q;
            e1_q <= push_entry_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_o  = e0_q;
  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);

endmodule

// File: rtl/vga_capture.sv
// VGA receive path: locks to h/v sync, packs 1-bpp active pixels into 32-bit words and writes them to SRAM.
// Define VGA_CAPTURE_SYNC_CHECK_EN to add the sync_err output and abort frames on a wrong line length.
module vga_capture
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_en,
  input  logic        h_in,
  input  logic        v_in,
  input  logic        pixel_in,
  input  logic        SRAM_busy,
  output logic        write_en,
  output logic [31:0] word_address_dest,
  output logic [31:0] SRAM_data_out,
  output logic [3:0]  byte_select,
  output logic        capturing,
  output logic        frame_done,
  output logic        overflow
`ifdef VGA_CAPTURE_SYNC_CHECK_EN
  ,
  output logic        sync_err
`endif
);

  localparam int unsigned CW      = CNT_W;
  localparam int unsigned H_START = H_SYNC + H_BACK;
  localparam int unsigned H_LAST  = H_START + H_ACTIVE - 1;
  localparam int unsigned H_TOTAL = H_START + H_ACTIVE + H_FRONT;
  localparam int unsigned V_START = V_SYNC + V_BACK;
  localparam int unsigned V_LAST  = V_START + V_ACTIVE - 1;
  localparam int unsigned V_STOP  = V_START + V_ACTIVE;
  localparam int unsigned WPL     = H_ACTIVE / 32;

  // Line length must fit the saturating 10-bit counter and active width must be whole words.
  if ((H_ACTIVE % 32) != 0 || H_TOTAL > 1024 || V_STOP > 1023) begin : g_bad_cfg
    $error("vga_capture: unsupported timing configuration");
  end

  cap_state_e       state_q;
  logic             h_q, v_q;
  logic             h_fall, v_fall;
  logic [CW-1:0]    hcnt_q, hcnt_d;
  logic [CW-1:0]    vcnt_q, vcnt_d;
  logic [CW-1:0]    x_w, y_w;
  logic             pix_act;
  logic [31:0]      shift_q, word_d;
  logic             push_q;
  fifo_entry_t      push_entry_q;
  logic             abort_q;
  logic             capturing_q;
  logic             frame_done_q;
  logic             overflow_q;
  fifo_entry_t      head;
  logic             fifo_empty, fifo_full;
  logic             pop;
`ifdef VGA_CAPTURE_SYNC_CHECK_EN
  logic             sync_err_q;
  logic             line_bad;
`endif

  assign h_fall = !h_in && h_q;
  assign v_fall = !v_in && v_q;

  // Line/frame counters; vsync edge wins over hsync edge on vcnt.
  always_comb begin
    hcnt_d = hcnt_q;
    if (h_fall)                    hcnt_d = '0;
    else if (hcnt_q != {CW{1'b1}}) hcnt_d = hcnt_q + CW'(1);
    vcnt_d = vcnt_q;
    if (v_fall)                              vcnt_d = '0;
    else if (h_fall && vcnt_q != {CW{1'b1}}) vcnt_d = vcnt_q + CW'(1);
  end

  assign x_w     = hcnt_q - CW'(H_START);
  assign y_w     = vcnt_q - CW'(V_START);
  assign pix_act = (state_q == CAPTURE)
                && (hcnt_q >= CW'(H_START)) && (hcnt_q <= CW'(H_LAST))
                && (vcnt_q >= CW'(V_START)) && (vcnt_q <= CW'(V_LAST));

  // Pixel x lands on bit 31-(x%32), i.e. the bitwise complement of the low five bits.
  always_comb begin
    word_d = shift_q;
    word_d[~x_w[4:0]] = pixel_in;
  end

`ifdef VGA_CAPTURE_SYNC_CHECK_EN
  assign line_bad = (hcnt_q != CW'(H_TOTAL - 1));
`endif

  assign pop = write_en && !SRAM_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      h_q          <= 1'b1;
      v_q          <= 1'b1;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      shift_q      <= '0;
      push_q       <= 1'b0;
      push_entry_q <= '0;
      abort_q      <= 1'b0;
      capturing_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef VGA_CAPTURE_SYNC_CHECK_EN
      sync_err_q   <= 1'b0;
`endif
    end else begin
      h_q          <= h_in;
      v_q          <= v_in;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      push_q       <= 1'b0;
      frame_done_q <= 1'b0;

      if (pix_act) begin
        shift_q <= word_d;
        if (&x_w[4:0]) begin
          push_q            <= 1'b1;
          push_entry_q.data <= word_d;
          push_entry_q.addr <= BASE_ADDR + 32'(y_w) * 32'(WPL) + 32'(x_w[CW-1:5]);
        end
      end

      if (push_q && fifo_full && !pop) overflow_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (capture_en) state_q <= WAIT_VSYNC;
        end
        WAIT_VSYNC: begin
          if (!capture_en) begin
            state_q <= IDLE;
          end else if (v_fall) begin
            state_q     <= CAPTURE;
            capturing_q <= 1'b1;
            abort_q     <= 1'b0;
          end
        end
        CAPTURE: begin
          if (!capture_en) begin
            state_q     <= DRAIN;
            capturing_q <= 1'b0;
            abort_q     <= 1'b1;
          end
`ifdef VGA_CAPTURE_SYNC_CHECK_EN
          else if (h_fall && line_bad) begin
            state_q     <= DRAIN;
            capturing_q <= 1'b0;
            abort_q     <= 1'b1;
            sync_err_q  <= 1'b1;
          end
`endif
          else if (h_fall && vcnt_d == CW'(V_STOP)) begin
            state_q     <= DRAIN;
            capturing_q <= 1'b0;
          end
        end
        DRAIN: begin
          // A word still in the push stage counts as queued.
          if (fifo_empty && !push_q) begin
            frame_done_q <= !abort_q;
            state_q      <= capture_en ? WAIT_VSYNC : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  vga_capture_fifo u_fifo (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (push_q),
    .push_entry_i (push_entry_q),
    .pop_i        (pop),
    .head_o       (head),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full)
  );

  assign write_en          = !fifo_empty;
  assign word_address_dest = head.addr;
  assign SRAM_data_out     = head.data;
  assign byte_select       = {4{write_en}};
  assign capturing         = capturing_q;
  assign frame_done        = frame_done_q;
  assign overflow          = overflow_q;
`ifdef VGA_CAPTURE_SYNC_CHECK_EN
  assign sync_err          = sync_err_q;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced 152x12 timing (128x6 active, 4 words per line).
module tb_vga_capture;
  import vga_pkg::*;

  localparam int HS = 8, HB = 8, HA = 128, HF = 8;
  localparam int VS = 2, VB = 2, VA = 6, VF = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int NL = VS + VB + VA + VF;
  localparam int WPL = HA / 32;
  localparam int NW = WPL * VA;
  localparam int PIX0_SC = HS + HB + 1;
  localparam int X31_SC = PIX0_SC + 31;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst, capture_en, h_in, v_in, pixel_in, SRAM_busy;
  logic write_en, capturing, frame_done, overflow;
  logic [31:0] word_address_dest, SRAM_data_out;
  logic [3:0] byte_select;
`ifdef VGA_CAPTURE_SYNC_CHECK_EN
  logic sync_err;
`endif

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int pix_mode = 0;
  int busy_ln = -1, busy_sc = 0, busy_len = 0;
  int drop_ln = -1, drop_sc = 0;
  int t31 = -1, first_we_cyc = -1, last_wr_cyc = -1, fd_cyc = -1;
  int fd_cnt = 0, bs_bad = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  vga_capture #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst), .capture_en(capture_en),
    .h_in(h_in), .v_in(v_in), .pixel_in(pixel_in), .SRAM_busy(SRAM_busy),
    .write_en(write_en), .word_address_dest(word_address_dest),
    .SRAM_data_out(SRAM_data_out), .byte_select(byte_select),
    .capturing(capturing), .frame_done(frame_done), .overflow(overflow)
`ifdef VGA_CAPTURE_SYNC_CHECK_EN
    , .sync_err(sync_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Write-side log: accepted writes, first write_en rise, frame_done pulses.
  always @(negedge clk) begin
    if (write_en && !SRAM_busy) begin
      wa_q.push_back(word_address_dest);
      wd_q.push_back(SRAM_data_out);
      last_wr_cyc = cyc;
      if (byte_select !== 4'hF) bs_bad++;
    end
    if (write_en && first_we_cyc < 0) first_we_cyc = cyc;
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  function automatic logic exp_pix(input int mode, input int x, input int y);
    if (mode == 0) return 1'b1;
    return (y == 0) && (x == 0 || x == 33);
  endfunction

  function automatic logic [31:0] exp_word(input int mode, input int y, input int w);
    logic [31:0] d;
    for (int i = 0; i < 32; i++) d[31-i] = exp_pix(mode, 32 * w + i, y);
    return d;
  endfunction

  function automatic logic src_pix(input int ln, input int sc);
    int x, y;
    x = sc - PIX0_SC;
    y = ln - (VS + VB);
    if (x < 0 || x >= HA || y < 0 || y >= VA) return (pix_mode == 1);
    return exp_pix(pix_mode, x, y);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    h_in = 1'b1;
    v_in = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_line(input int ln, input int len);
    for (int sc = 0; sc < len; sc++) begin
      h_in      = (sc >= HS);
      v_in      = (ln >= VS);
      pixel_in  = src_pix(ln, sc);
      SRAM_busy = (ln == busy_ln) && (sc >= busy_sc) && (sc < busy_sc + busy_len);
      if (ln == drop_ln && sc == drop_sc) capture_en = 1'b0;
      tick();
      if (ln == VS + VB && sc == X31_SC) t31 = cyc;
    end
  endtask

  task automatic run_frame(input int short_ln);
    for (int ln = 0; ln < NL; ln++) drive_line(ln, (ln == short_ln) ? HT - 1 : HT);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    fd_cnt = 0;
    fd_cyc = -1;
    last_wr_cyc = -1;
    first_we_cyc = -1;
    t31 = -1;
    bs_bad = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; capture_en = 1'b1; h_in = 1'b1; v_in = 1'b1;
    pixel_in = 1'b0; SRAM_busy = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({write_en, capturing, frame_done, overflow, byte_select} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_flags: got we=%b cap=%b fd=%b ovf=%b bs=%h, need all 0",
               write_en, capturing, frame_done, overflow, byte_select);
    end
    n_checks++;
    if (word_address_dest !== 32'h0 || SRAM_data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr=%h data=%h, need 0", word_address_dest, SRAM_data_out);
    end
    n_checks++;
    if (dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, need IDLE", dut.state_q);
    end
`ifdef VGA_CAPTURE_SYNC_CHECK_EN
    n_checks++;
    if (sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sync_err: got %b, need 0", sync_err);
    end
`endif
    rst = 1'b0;
    tick();
    n_checks++;
    if (dut.state_q !== WAIT_VSYNC) begin
      n_fail++;
      $display("FAIL release_state: got %0d, need WAIT_VSYNC", dut.state_q);
    end
  endtask

  task automatic test_full_frame();
    clear_log();
    pix_mode = 0;
    for (int ln = 0; ln < NL; ln++) begin
      drive_line(ln, HT);
      if (ln == 5) begin
        n_checks++;
        if (capturing !== 1'b1) begin
          n_fail++;
          $display("FAIL full_capturing: got %b, need 1", capturing);
        end
      end
    end
    n_checks++;
    if (wa_q.size() != NW) begin
      n_fail++;
      $display("FAIL full_count: got %0d writes, need %0d", wa_q.size(), NW);
    end
    for (int i = 0; i < wa_q.size() && i < NW; i++) begin
      n_checks++;
      if (wa_q[i] !== BASE + 32'(i) || wd_q[i] !== 32'hFFFF_FFFF) begin
        n_fail++;
        $display("FAIL full_word[%0d]: got addr=%h data=%h, need addr=%h data=ffffffff",
                 i, wa_q[i], wd_q[i], BASE + 32'(i));
      end
    end
    n_checks++;
    if (fd_cnt != 1 || fd_cyc <= last_wr_cyc) begin
      n_fail++;
      $display("FAIL full_frame_done: got %0d pulses at cyc %0d (last write %0d), need 1 after last write",
               fd_cnt, fd_cyc, last_wr_cyc);
    end
    n_checks++;
    if (dut.state_q !== WAIT_VSYNC || capturing !== 1'b0 || bs_bad != 0) begin
      n_fail++;
      $display("FAIL full_end: got state=%0d cap=%b bs_bad=%0d, need WAIT_VSYNC 0 0",
               dut.state_q, capturing, bs_bad);
    end
  endtask

  task automatic test_sparse_line();
    clear_log();
    pix_mode = 1;
    run_frame(-1);
    n_checks++;
    if (wa_q.size() != NW) begin
      n_fail++;
      $display("FAIL sparse_count: got %0d writes, need %0d", wa_q.size(), NW);
    end
    n_checks++;
    if (wa_q.size() < 2 || wa_q[0] !== BASE || wd_q[0] !== 32'h8000_0000 ||
        wa_q[1] !== BASE + 32'd1 || wd_q[1] !== 32'h4000_0000) begin
      n_fail++;
      $display("FAIL sparse_first_words: got %h/%h %h/%h, need %h/80000000 %h/40000000",
               wa_q[0], wd_q[0], wa_q[1], wd_q[1], BASE, BASE + 32'd1);
    end
    for (int i = 2; i < wa_q.size() && i < NW; i++) begin
      n_checks++;
      if (wa_q[i] !== BASE + 32'(i) || wd_q[i] !== exp_word(1, i / WPL, i % WPL)) begin
        n_fail++;
        $display("FAIL sparse_word[%0d]: got %h/%h, need %h/%h",
                 i, wa_q[i], wd_q[i], BASE + 32'(i), exp_word(1, i / WPL, i % WPL));
      end
    end
    n_checks++;
    if (first_we_cyc != t31 + 1) begin
      n_fail++;
      $display("FAIL sparse_latency: got write_en at cyc %0d, need %0d", first_we_cyc, t31 + 1);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_a[$];
    clear_log();
    pix_mode = 0;
    busy_ln = VS + VB; busy_sc = X31_SC + 1; busy_len = 70;
    run_frame(-1);
    busy_ln = -1;
    SRAM_busy = 1'b0;
    for (int i = 0; i < NW; i++) if (i != 2) exp_a.push_back(BASE + 32'(i));
    n_checks++;
    if (wa_q.size() != NW - 1) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d writes, need %0d", wa_q.size(), NW - 1);
    end
    for (int i = 0; i < wa_q.size() && i < NW - 1; i++) begin
      n_checks++;
      if (wa_q[i] !== exp_a[i] || wd_q[i] !== 32'hFFFF_FFFF) begin
        n_fail++;
        $display("FAIL ovf_word[%0d]: got %h/%h, need %h/ffffffff", i, wa_q[i], wd_q[i], exp_a[i]);
      end
    end
    n_checks++;
    if (overflow !== 1'b1 || fd_cnt != 1) begin
      n_fail++;
      $display("FAIL ovf_flag: got overflow=%b frame_done=%0d, need 1 1", overflow, fd_cnt);
    end
    clear_log();
    run_frame(-1);
    n_checks++;
    if (wa_q.size() != NW || wa_q[2] !== BASE + 32'd2 || wa_q[NW-1] !== BASE + 32'(NW - 1)) begin
      n_fail++;
      $display("FAIL ovf_next_frame: got %0d writes, addr2=%h, need %0d writes addr2=%h",
               wa_q.size(), wa_q[2], NW, BASE + 32'd2);
    end
    n_checks++;
    if (overflow !== 1'b1 || fd_cnt != 1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got overflow=%b frame_done=%0d, need 1 1", overflow, fd_cnt);
    end
  endtask

  task automatic test_capture_abort();
    clear_log();
    pix_mode = 0;
    drop_ln = VS + VB + 2; drop_sc = 60;
    run_frame(-1);
    drop_ln = -1;
    n_checks++;
    if (wa_q.size() != 2 * WPL + 1 || wa_q[2 * WPL] !== BASE + 32'(2 * WPL)) begin
      n_fail++;
      $display("FAIL abort_writes: got %0d writes, need %0d ending at %h",
               wa_q.size(), 2 * WPL + 1, BASE + 32'(2 * WPL));
    end
    n_checks++;
    if (fd_cnt != 0 || dut.state_q !== IDLE || capturing !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_end: got fd=%0d state=%0d cap=%b, need 0 IDLE 0",
               fd_cnt, dut.state_q, capturing);
    end
    capture_en = 1'b1;
    idle(2);
  endtask

`ifdef VGA_CAPTURE_SYNC_CHECK_EN
  task automatic test_sync_check();
    n_checks++;
    if (sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_pre: got sync_err=%b after good frames, need 0", sync_err);
    end
    clear_log();
    pix_mode = 0;
    run_frame(VS + VB + 1);
    n_checks++;
    if (sync_err !== 1'b1 || fd_cnt != 0 || wa_q.size() != 2 * WPL) begin
      n_fail++;
      $display("FAIL sync_short_line: got sync_err=%b fd=%0d writes=%0d, need 1 0 %0d",
               sync_err, fd_cnt, wa_q.size(), 2 * WPL);
    end
    n_checks++;
    if (dut.state_q !== WAIT_VSYNC) begin
      n_fail++;
      $display("FAIL sync_state: got %0d, need WAIT_VSYNC", dut.state_q);
    end
  endtask
`endif

  task automatic test_reset_midwrite();
    clear_log();
    pix_mode = 0;
    busy_ln = VS + VB; busy_sc = X31_SC + 1; busy_len = HT;
    for (int ln = 0; ln <= VS + VB; ln++) drive_line(ln, HT);
    busy_ln = -1;
    n_checks++;
    if (write_en !== 1'b1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL midwrite_pre: got we=%b ovf=%b, need 1 1", write_en, overflow);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (write_en !== 1'b0 || byte_select !== 4'h0 || overflow !== 1'b0 || dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL midwrite_rst: got we=%b bs=%h ovf=%b state=%0d, need 0 0 0 IDLE",
               write_en, byte_select, overflow, dut.state_q);
    end
    rst = 1'b0;
    SRAM_busy = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_sparse_line();
    test_overflow();
    test_capture_abort();
`ifdef VGA_CAPTURE_SYNC_CHECK_EN
    test_sync_check();
`endif
    test_reset_midwrite();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
